// File: rtl/stn_capture_pkg.sv
// Shared types and geometry defaults for the STN panel capture block.
package stn_capture_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // 640x480 mono at 4 pixels per shift clock
    localparam int unsigned DEF_MAX_WORDS   = 160;
    localparam int unsigned DEF_MAX_LINES   = 480;
    localparam int unsigned DEF_LINE_STRIDE = 160;

    function automatic int unsigned words_to_pixels(input int unsigned words,
                                                    input int unsigned data_w);
        return words * data_w;
    endfunction

endpackage

// File: rtl/stn_sync_edge.sv
// N-stage synchroniser followed by one edge register; level output is delayed
// to stay aligned with the registered rise/fall flags.
module stn_sync_edge #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             prev_q;
    logic [W-1:0]             rise_q;
    logic [W-1:0]             fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign q_o    = prev_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/stn_capture.sv
// Oversampling capture of an STN LCD controller bus into framebuffer write
// strobes, with live and per-frame geometry measurement.
module stn_capture
    import stn_capture_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 9,
    parameter int unsigned MAX_WORDS   = DEF_MAX_WORDS,
    parameter int unsigned MAX_LINES   = DEF_MAX_LINES,
    parameter int unsigned LINE_STRIDE = DEF_LINE_STRIDE,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lflm,
    input  logic              llp,
    input  logic              lck,
    input  logic [DATA_W-1:0] ld,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [X_W-1:0]    frame_x,
    output logic [Y_W-1:0]    frame_y,
    output logic [X_W-1:0]    frame_width,
    output logic [Y_W-1:0]    frame_height,
    output logic              frame_valid,
    output logic              overflow
);

    localparam int unsigned XC_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned YC_W = $clog2(MAX_LINES + 1);

    logic [2:0]        ctrl_q, ctrl_rise, ctrl_fall;
    logic [DATA_W-1:0] ld_s, ld_rise, ld_fall;
    logic              lflm_s, llp_rise, lck_fall;

    stn_sync_edge #(.W(3), .STAGES(SYNC_STAGES)) u_ctrl_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    ({lflm, llp, lck}),
        .q_o    (ctrl_q),
        .rise_o (ctrl_rise),
        .fall_o (ctrl_fall)
    );

    stn_sync_edge #(.W(DATA_W), .STAGES(SYNC_STAGES)) u_data_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (ld),
        .q_o    (ld_s),
        .rise_o (ld_rise),
        .fall_o (ld_fall)
    );

    assign lflm_s   = ctrl_q[2];
    assign llp_rise = ctrl_rise[1];
    assign lck_fall = ctrl_fall[0];

    logic unused_ok;
    assign unused_ok = ^{ctrl_q[1:0], ctrl_rise[2], ctrl_rise[0], ctrl_fall[2:1],
                         ld_rise, ld_fall};

    state_e            state_q, state_d;
    logic [XC_W-1:0]   x_q, x_d;
    logic [YC_W-1:0]   y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [X_W-1:0]    fx_q, fx_d, fw_q, fw_d;
    logic [Y_W-1:0]    fy_q, fy_d, fh_q, fh_d;
    logic              fv_q, fv_d;
    logic              ovf_q, ovf_d;

    // Word capture first, then line-end updates, so a coincident word lands on the old line
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fw_d      = fw_q;
        fh_d      = fh_q;
        fv_d      = fv_q;
        ovf_d     = ovf_q;

        case (state_q)
            HUNT: begin
                if (llp_rise && lflm_s) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                end
            end
            ACTIVE: begin
                if (lck_fall) begin
                    if (x_q < XC_W'(MAX_WORDS) && y_q < YC_W'(MAX_LINES)) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = ld_s;
                        wr_addr_d = base_q + ADDR_W'(x_q);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (x_q < XC_W'(MAX_WORDS)) begin
                        x_d = x_q + XC_W'(1);
                    end
                end
                if (llp_rise) begin
                    fw_d = X_W'(words_to_pixels(32'(x_d), DATA_W));
                    x_d  = '0;
                    if (lflm_s) begin
                        fh_d   = Y_W'(32'(y_q) + 32'd1);
                        fv_d   = 1'b1;
                        y_d    = '0;
                        base_d = '0;
                    end else begin
                        if (y_q < YC_W'(MAX_LINES)) begin
                            y_d = y_q + YC_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        base_d = base_q + ADDR_W'(LINE_STRIDE);
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        fx_d = X_W'(words_to_pixels(32'(x_d), DATA_W));
        fy_d = Y_W'(y_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            fw_q      <= '0;
            fh_q      <= '0;
            fv_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            fw_q      <= fw_d;
            fh_q      <= fh_d;
            fv_q      <= fv_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_x      = fx_q;
    assign frame_y      = fy_q;
    assign frame_width  = fw_q;
    assign frame_height = fh_q;
    assign frame_valid  = fv_q;
    assign overflow     = ovf_q;

endmodule
